// File: rtl/cnn_pkg.sv
// Shared CNN front-end constants and types (line buffer, window buffer, MAC array).
package cnn_pkg;

  localparam int WIDTH       = 28;
  localparam int HEIGHT      = 28;
  localparam int KERNEL_SIZE = 5;
  localparam int DATA_W      = 8;
  localparam int OUT_W       = WIDTH - KERNEL_SIZE + 1;
  localparam int OUT_H       = HEIGHT - KERNEL_SIZE + 1;

  // Wide enough for column position (0..WIDTH-1) and output coordinates.
  localparam int COORD_W     = 5;
  localparam int COL_W       = KERNEL_SIZE * DATA_W;
  localparam int WIN_W       = KERNEL_SIZE * KERNEL_SIZE * DATA_W;

  typedef logic [DATA_W-1:0] pixel_t;

  // Window-row phase, derived from the column position counter.
  typedef enum logic {
    PH_FILL  = 1'b0,
    PH_SLIDE = 1'b1
  } win_phase_e;

endpackage

// File: rtl/window_shift_array.sv
// KERNEL_SIZE x KERNEL_SIZE pixel register array. Each shift moves every
// row one column left and loads the incoming column at the rightmost slot.
module window_shift_array
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en_i,
  input  logic [COL_W-1:0] col_i,
  output logic [WIN_W-1:0] win_o
);

  pixel_t arr_q [KERNEL_SIZE][KERNEL_SIZE];

  // Shift left by one column and load the new column at c = KERNEL_SIZE-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          arr_q[r][c] <= '0;
        end
      end
    end else if (shift_en_i) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
          arr_q[r][c] <= arr_q[r][c+1];
        end
        arr_q[r][KERNEL_SIZE-1] <= col_i[r*DATA_W +: DATA_W];
      end
    end
  end

  // Flatten: pixel (r,c) at [(r*KERNEL_SIZE+c)*DATA_W +: DATA_W].
  always_comb begin
    win_o = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        win_o[(r*KERNEL_SIZE+c)*DATA_W +: DATA_W] = arr_q[r][c];
      end
    end
  end

endmodule

// File: rtl/conv_window_buffer.sv
// Sliding-window assembler between the line buffer and the conv MAC array.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   PH_FILL  | col_cnt < KERNEL_SIZE-1: accepted column only fills array
//   PH_SLIDE | otherwise: accepted column completes a window at
//            | x = col_cnt-(KERNEL_SIZE-1), y = row_cnt
//
// The phase is decoded from col_cnt rather than stored separately, so the
// counter is the single source of truth for row position.
module conv_window_buffer
  import cnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COL_W-1:0]   col_data,
  input  logic               valid_line_win,
  output logic               ready_win,
  output logic [WIN_W-1:0]   win_data,
  output logic               win_valid,
  input  logic               ready_conv,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  output logic               win_last
);

  localparam logic [COORD_W-1:0] FILL_COLS = COORD_W'(KERNEL_SIZE - 1);
  localparam logic [COORD_W-1:0] COL_LAST  = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] ROW_LAST  = COORD_W'(OUT_H - 1);
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(OUT_W - 1);

  logic [COORD_W-1:0] col_cnt_q, col_cnt_d;
  logic [COORD_W-1:0] row_cnt_q, row_cnt_d;
  logic [COORD_W-1:0] win_x_q, win_x_d;
  logic [COORD_W-1:0] win_y_q, win_y_d;
  logic               win_valid_q, win_valid_d;
  logic               win_last_q, win_last_d;
  logic               hs_col, hs_win;
  win_phase_e         phase;

  // A pending window blocks new columns so the array never moves under it.
  assign ready_win = !win_valid_q | ready_conv;
  assign hs_col    = valid_line_win & ready_win;
  assign hs_win    = win_valid_q & ready_conv;
  assign phase     = (col_cnt_q < FILL_COLS) ? PH_FILL : PH_SLIDE;

  window_shift_array u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (hs_col),
    .col_i      (col_data),
    .win_o      (win_data)
  );

  // Next-state: position counters, window valid and coordinate capture.
  always_comb begin
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;

    if (hs_col) begin
      if (col_cnt_q == COL_LAST) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end

      if (phase == PH_SLIDE) begin
        win_valid_d = 1'b1;
        win_x_d     = col_cnt_q - FILL_COLS;
        win_y_d     = row_cnt_q;
        win_last_d  = (col_cnt_q == COL_LAST) && (row_cnt_q == ROW_LAST);
      end else if (hs_win) begin
        win_valid_d = 1'b0;
      end
    end else if (hs_win) begin
      win_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign win_last  = win_last_q;

  // The coordinate check below relies on X_LAST matching the last slide column.
  logic unused_x_last;
  assign unused_x_last = (X_LAST == COL_LAST - FILL_COLS);

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer: reset, fill, stall, row wrap,
// full image with random backpressure, and mid-row reset.
module tb_conv_window_buffer;

  localparam int K    = 5;
  localparam int DW   = 8;
  localparam int CW   = K * DW;
  localparam int WW   = K * K * DW;
  localparam int IMGW = 28;
  localparam int OW   = 24;
  localparam int OH   = 24;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] col_data;
  logic          valid_line_win;
  logic          ready_win;
  logic [WW-1:0] win_data;
  logic          win_valid;
  logic          ready_conv;
  logic [4:0]    win_x;
  logic [4:0]    win_y;
  logic          win_last;

  int n_cmp = 0;
  int n_mis = 0;

  conv_window_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .col_data       (col_data),
    .valid_line_win (valid_line_win),
    .ready_win      (ready_win),
    .win_data       (win_data),
    .win_valid      (win_valid),
    .ready_conv     (ready_conv),
    .win_x          (win_x),
    .win_y          (win_y),
    .win_last       (win_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Column k: lane r carries 10r+k (mod 256).
  function automatic logic [CW-1:0] col_of(int k);
    logic [CW-1:0] c;
    c = '0;
    for (int r = 0; r < K; r++) c[r*DW +: DW] = 8'(10*r + k);
    return c;
  endfunction

  // Window built from columns first..first+4: pixel(r,c) = 10r+first+c.
  function automatic logic [WW-1:0] exp_win(int first);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DW +: DW] = 8'(10*r + first + c);
    return w;
  endfunction

  task automatic chk1(input string tag, input logic o, input logic e);
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] o, input logic [4:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic chkw(input string tag, input logic [WW-1:0] o, input logic [WW-1:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chki(input string tag, input int o, input int e);
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    valid_line_win = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int nwin, acc, pos, cyc, lastcnt, p;
    logic exp_v, rc, vl, exp_rdy, hsw, hsc;
    logic [WW-1:0] exp_d;

    rst_n          = 1'b0;
    valid_line_win = 1'b0;
    ready_conv     = 1'b1;
    col_data       = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset values
    chk1("rst_valid", win_valid, 1'b0);
    chk5("rst_x", win_x, 5'd0);
    chk5("rst_y", win_y, 5'd0);
    chk1("rst_last", win_last, 1'b0);
    chk1("rst_ready", ready_win, 1'b1);
    chkw("rst_data", win_data, '0);

    // Fill five columns, first window appears after the fifth
    valid_line_win = 1'b1;
    for (int k = 0; k < 5; k++) begin
      col_data = col_of(k);
      tick();
      if (k < 4) chk1("fill_novalid", win_valid, 1'b0);
    end
    chk1("first_valid", win_valid, 1'b1);
    chk5("first_x", win_x, 5'd0);
    chk5("first_y", win_y, 5'd0);
    chk1("first_last", win_last, 1'b0);
    chkw("first_data", win_data, exp_win(0));

    // Engine stall: window held, column 5 blocked
    ready_conv = 1'b0;
    col_data   = col_of(5);
    #1;
    chk1("stall_ready", ready_win, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("stall_valid", win_valid, 1'b1);
      chk1("stall_ready_hold", ready_win, 1'b0);
      chk5("stall_x", win_x, 5'd0);
      chkw("stall_data", win_data, exp_win(0));
    end
    ready_conv = 1'b1;
    #1;
    chk1("release_ready", ready_win, 1'b1);
    tick();
    chk1("release_valid", win_valid, 1'b1);
    chk5("release_x", win_x, 5'd1);
    chkw("release_data", win_data, exp_win(1));
    valid_line_win = 1'b0;
    tick();
    chk1("drain_valid", win_valid, 1'b0);

    // 33-column stream across a row boundary
    do_reset();
    ready_conv     = 1'b1;
    valid_line_win = 1'b1;
    nwin = 0;
    for (int k = 0; k < 33; k++) begin
      col_data = col_of(k);
      tick();
      p = k % IMGW;
      if (p >= 4) begin
        chk1("strm_valid", win_valid, 1'b1);
        chk5("strm_x", win_x, 5'(p - 4));
        chk5("strm_y", win_y, 5'(k / IMGW));
        chk1("strm_last", win_last, 1'b0);
        chkw("strm_data", win_data, exp_win(k - 4));
        nwin++;
      end else begin
        chk1("strm_novalid", win_valid, 1'b0);
      end
    end
    chki("strm_count", nwin, 25);
    valid_line_win = 1'b0;
    tick();

    // Full image with random backpressure
    do_reset();
    acc = 0; nwin = 0; pos = 0; cyc = 0; lastcnt = 0;
    exp_v = 1'b0;
    exp_d = '0;
    while ((acc < OW*0 + IMGW*OH || exp_v) && cyc < 6000) begin
      rc             = 1'($urandom_range(0, 1));
      vl             = (acc < IMGW*OH);
      ready_conv     = rc;
      valid_line_win = vl;
      col_data       = col_of(acc);
      #1;
      exp_rdy = !exp_v || rc;
      chk1("img_ready", ready_win, exp_rdy);
      chk1("img_valid", win_valid, exp_v);
      hsw = exp_v && rc;
      if (hsw) begin
        chk5("img_x", win_x, 5'(nwin % OW));
        chk5("img_y", win_y, 5'(nwin / OW));
        chk1("img_last", win_last, (nwin == OW*OH - 1));
        chkw("img_data", win_data, exp_d);
        if (win_last) lastcnt++;
        nwin++;
      end
      hsc = vl && exp_rdy;
      tick();
      if (hsc) begin
        if (pos >= 4) begin
          exp_v = 1'b1;
          exp_d = exp_win(acc - 4);
        end else if (hsw) begin
          exp_v = 1'b0;
        end
        pos = (pos == IMGW - 1) ? 0 : pos + 1;
        acc++;
      end else if (hsw) begin
        exp_v = 1'b0;
      end
      cyc++;
    end
    chki("img_cols", acc, IMGW*OH);
    chki("img_windows", nwin, OW*OH);
    chki("img_last_count", lastcnt, 1);
    chk1("img_drained", exp_v, 1'b0);

    // Next image starts again at the top
    ready_conv     = 1'b1;
    valid_line_win = 1'b1;
    for (int k = 0; k < 5; k++) begin
      col_data = col_of(k);
      tick();
    end
    chk1("next_valid", win_valid, 1'b1);
    chk5("next_x", win_x, 5'd0);
    chk5("next_y", win_y, 5'd0);
    chk1("next_last", win_last, 1'b0);
    chkw("next_data", win_data, exp_win(0));
    valid_line_win = 1'b0;
    tick();

    // Reset after a partial row discards it
    do_reset();
    ready_conv     = 1'b1;
    valid_line_win = 1'b1;
    for (int k = 0; k < 3; k++) begin
      col_data = col_of(k);
      tick();
    end
    do_reset();
    #1;
    chk1("mrst_valid", win_valid, 1'b0);
    chkw("mrst_data", win_data, '0);
    valid_line_win = 1'b1;
    for (int k = 100; k < 105; k++) begin
      col_data = col_of(k);
      tick();
      if (k < 104) chk1("mrst_novalid", win_valid, 1'b0);
    end
    chk1("mrst_win_valid", win_valid, 1'b1);
    chk5("mrst_x", win_x, 5'd0);
    chk5("mrst_y", win_y, 5'd0);
    chkw("mrst_data_win", win_data, exp_win(100));
    valid_line_win = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
